aquarium_sensor_bank: RTL and testbench

- Parametrised successor to the fixed four-channel tank register set and one-hot output mux.
- Holds NCH sensor channels of WIDTH bits: cleanliness, temperature, food storage, saltiness, plus any further channels.
- Each channel has programmable low/high thresholds and a sticky out-of-range alarm.
- Drives one registered output that is either host-selected (manual) or auto-scanned, with an error mode that forces all-ones.

---
 rtl/aquarium_sensor_bank.sv | 188 ++++++++++++++++++
 tb/tb_aquarium_sensor_bank.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/aquarium_sensor_bank.sv
// NCH-channel sensor register bank with per-channel threshold alarms and a registered manual/scan output.
// Define AQUARIUM_ALARM_SCAN_EN to make the scan visit only alarmed channels.
module aquarium_sensor_bank #(
  parameter int WIDTH    = 8,
  parameter int NCH      = 4,
  parameter int CHW      = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             thr_we,
  input  logic [CHW-1:0]   thr_ch,
  input  logic [WIDTH-1:0] thr_lo,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic             mode,
  input  logic [CHW-1:0]   sel_ch,
  input  logic [NCH-1:0]   alarm_clr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] out_data,
  output logic [CHW-1:0]   out_ch,
  output logic             out_valid,
  output logic             scan_wrap,
  output logic [NCH-1:0]   alarm,
  output logic             err
);

  localparam int              CNTW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SCAN_DIV - 1);
  localparam logic [CHW:0]    NCH_W    = (CHW + 1)'(NCH);
  localparam logic [CHW-1:0]  LAST_CH  = CHW'(NCH - 1);

  typedef enum logic [1:0] {MANUAL, SCAN, ERROR} state_t;

  logic [WIDTH-1:0] data_q [NCH];
  logic [WIDTH-1:0] lo_q   [NCH];
  logic [WIDTH-1:0] hi_q   [NCH];

  state_t           state, state_nxt;
  logic [CNTW-1:0]  cnt, cnt_nxt;
  logic [WIDTH-1:0] out_data_nxt;
  logic [CHW-1:0]   out_ch_nxt;
  logic             out_valid_nxt, scan_wrap_nxt, err_nxt;
  logic [NCH-1:0]   alarm_set;
  logic             sel_bad;
  logic [CHW-1:0]   scan_next, first_ch;
  logic             scan_wraps;

  // Channel indices that do not fit in the bank are decoded by compare, never used as raw array indices.
  function automatic logic [WIDTH-1:0] rd(input logic [WIDTH-1:0] arr [NCH], input logic [CHW-1:0] idx);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++)
      if (idx == CHW'(i)) v = arr[i];
    return v;
  endfunction

  assign sel_bad = {1'b0, sel_ch} >= NCH_W;

  always_comb begin
    alarm_set = '0;
    for (int i = 0; i < NCH; i++)
      if (wr_en && wr_ch == CHW'(i) && (wr_data < lo_q[i] || wr_data > hi_q[i]))
        alarm_set[i] = 1'b1;
  end

`ifdef AQUARIUM_ALARM_SCAN_EN
  logic [CHW-1:0] lowest, above;
  logic           found_above;
`endif

  always_comb begin
    scan_next  = (out_ch == LAST_CH) ? '0 : out_ch + CHW'(1);
    scan_wraps = (out_ch == LAST_CH);
    first_ch   = '0;
`ifdef AQUARIUM_ALARM_SCAN_EN
    lowest      = '0;
    above       = '0;
    found_above = 1'b0;
    // Descending search leaves the smallest alarmed index, overall and above the current one.
    if (alarm != '0) begin
      for (int j = NCH - 1; j >= 0; j--) begin
        if (alarm[j]) lowest = CHW'(j);
        if (alarm[j] && CHW'(j) > out_ch) begin
          above       = CHW'(j);
          found_above = 1'b1;
        end
      end
      first_ch   = lowest;
      scan_next  = found_above ? above : lowest;
      scan_wraps = !found_above;
    end
`endif
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    out_data_nxt  = out_data;
    out_ch_nxt    = out_ch;
    out_valid_nxt = out_valid;
    scan_wrap_nxt = 1'b0;
    err_nxt       = err;
    case (state)
      MANUAL: begin
        if (sel_bad) begin
          state_nxt     = ERROR;
          out_data_nxt  = '1;
          out_ch_nxt    = '1;
          out_valid_nxt = 1'b0;
          err_nxt       = 1'b1;
        end else if (mode) begin
          state_nxt     = SCAN;
          cnt_nxt       = '0;
          out_ch_nxt    = first_ch;
          out_data_nxt  = rd(data_q, first_ch);
          out_valid_nxt = 1'b1;
        end else begin
          out_ch_nxt    = sel_ch;
          out_data_nxt  = rd(data_q, sel_ch);
          out_valid_nxt = 1'b1;
        end
      end
      SCAN: begin
        out_valid_nxt = 1'b1;
        // Leaving scan holds the shown channel; sel_ch is picked up on the following edge.
        if (!mode) begin
          state_nxt    = MANUAL;
          out_data_nxt = rd(data_q, out_ch);
        end else if (cnt == CNT_LAST) begin
          cnt_nxt       = '0;
          out_ch_nxt    = scan_next;
          out_data_nxt  = rd(data_q, scan_next);
          scan_wrap_nxt = scan_wraps;
        end else begin
          cnt_nxt      = cnt + CNTW'(1);
          out_data_nxt = rd(data_q, out_ch);
        end
      end
      default: begin
        out_data_nxt  = '1;
        out_ch_nxt    = '1;
        out_valid_nxt = 1'b0;
        if (err_clr && !sel_bad) begin
          state_nxt = MANUAL;
          err_nxt   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        data_q[i] <= '0;
        lo_q[i]   <= '0;
        hi_q[i]   <= '1;
      end
      alarm     <= '0;
      state     <= MANUAL;
      cnt       <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      scan_wrap <= 1'b0;
      err       <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_en && wr_ch == CHW'(i)) data_q[i] <= wr_data;
        if (thr_we && thr_ch == CHW'(i)) begin
          lo_q[i] <= thr_lo;
          hi_q[i] <= thr_hi;
        end
      end
      alarm     <= (alarm & ~alarm_clr) | alarm_set;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_data  <= out_data_nxt;
      out_ch    <= out_ch_nxt;
      out_valid <= out_valid_nxt;
      scan_wrap <= scan_wrap_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_aquarium_sensor_bank.sv
// Scoreboard bench for aquarium_sensor_bank: each stimulus cycle queues its expected outputs,
// and a negedge monitor pops and compares them.
module tb_aquarium_sensor_bank;

  localparam int WIDTH = 8, NCH = 4, CHW = 4, SCAN_DIV = 4;

  logic             CLK = 1'b0;
  logic             reset;
  logic             wr_en, thr_we, mode, err_clr;
  logic [CHW-1:0]   wr_ch, thr_ch, sel_ch;
  logic [WIDTH-1:0] wr_data, thr_lo, thr_hi;
  logic [NCH-1:0]   alarm_clr;
  logic [WIDTH-1:0] out_data;
  logic [CHW-1:0]   out_ch;
  logic             out_valid, scan_wrap, err;
  logic [NCH-1:0]   alarm;

  always #5 CLK = ~CLK;

  aquarium_sensor_bank #(.WIDTH(WIDTH), .NCH(NCH), .CHW(CHW), .SCAN_DIV(SCAN_DIV)) dut (
    .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .thr_we(thr_we), .thr_ch(thr_ch), .thr_lo(thr_lo), .thr_hi(thr_hi),
    .mode(mode), .sel_ch(sel_ch), .alarm_clr(alarm_clr), .err_clr(err_clr),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .scan_wrap(scan_wrap),
    .alarm(alarm), .err(err)
  );

  typedef struct {
    string      name;
    bit         c_out;
    logic [7:0] d;
    logic [3:0] ch;
    logic       v;
    bit         c_wrap;
    logic       wrap;
    bit         c_al;
    logic [3:0] al;
    bit         c_err;
    logic       e;
  } exp_t;

  exp_t sb[$];
  exp_t nxt;
  int   checks   = 0;
  int   failures = 0;

  task automatic clearExp();
    nxt.name   = "";
    nxt.c_out  = 1'b0; nxt.d = '0; nxt.ch = '0; nxt.v = 1'b0;
    nxt.c_wrap = 1'b0; nxt.wrap = 1'b0;
    nxt.c_al   = 1'b0; nxt.al = '0;
    nxt.c_err  = 1'b0; nxt.e = 1'b0;
  endtask

  task automatic expOut(input logic [7:0] d, input logic [3:0] ch, input logic v);
    nxt.c_out = 1'b1; nxt.d = d; nxt.ch = ch; nxt.v = v;
  endtask

  task automatic expWrap(input logic w);
    nxt.c_wrap = 1'b1; nxt.wrap = w;
  endtask

  task automatic expAlarm(input logic [3:0] a);
    nxt.c_al = 1'b1; nxt.al = a;
  endtask

  task automatic expErr(input logic e);
    nxt.c_err = 1'b1; nxt.e = e;
  endtask

  task automatic cmpField(input string nm, input string field, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s.%s got=%0h expected=%0h", nm, field, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    if (e.c_out) begin
      cmpField(e.name, "out_data", 32'(out_data), 32'(e.d));
      cmpField(e.name, "out_ch", 32'(out_ch), 32'(e.ch));
      cmpField(e.name, "out_valid", 32'(out_valid), 32'(e.v));
    end
    if (e.c_wrap) cmpField(e.name, "scan_wrap", 32'(scan_wrap), 32'(e.wrap));
    if (e.c_al) cmpField(e.name, "alarm", 32'(alarm), 32'(e.al));
    if (e.c_err) cmpField(e.name, "err", 32'(err), 32'(e.e));
  endtask

  // Pushes this cycle's expectation, clocks once, then drops the single-cycle strobes.
  task automatic applyStimulus(input string nm);
    nxt.name = nm;
    sb.push_back(nxt);
    clearExp();
    @(posedge CLK);
    #1;
    wr_en = 1'b0; thr_we = 1'b0; alarm_clr = '0; err_clr = 1'b0;
  endtask

  task automatic doWrite(input logic [3:0] ch, input logic [7:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_data = d;
  endtask

  task automatic doThr(input logic [3:0] ch, input logic [7:0] lo, input logic [7:0] hi);
    thr_we = 1'b1; thr_ch = ch; thr_lo = lo; thr_hi = hi;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  logic [7:0] scan_vals [4] = '{8'h0E, 8'h30, 8'h38, 8'h70};

  initial begin
    logic [7:0] v;
    reset = 1'b1; wr_en = 1'b0; thr_we = 1'b0; mode = 1'b0; err_clr = 1'b0;
    wr_ch = '0; thr_ch = '0; sel_ch = '0; wr_data = '0; thr_lo = '0; thr_hi = '0; alarm_clr = '0;
    clearExp();
    #1;

    expOut(8'h00, 4'h0, 1'b0); expWrap(1'b0); expAlarm(4'b0000); expErr(1'b0);
    applyStimulus("reset");
    reset = 1'b0;

    // Fill the bank and walk the manual select one cycle behind.
    doWrite(4'd0, 8'h0E); expOut(8'h00, 4'd0, 1'b1); applyStimulus("wr0");
    doWrite(4'd1, 8'h1C); expOut(8'h0E, 4'd0, 1'b1); applyStimulus("wr1");
    doWrite(4'd2, 8'h38); sel_ch = 4'd1; expOut(8'h1C, 4'd1, 1'b1); applyStimulus("wr2_sel1");
    doWrite(4'd3, 8'h70); sel_ch = 4'd2; expOut(8'h38, 4'd2, 1'b1); applyStimulus("wr3_sel2");
    sel_ch = 4'd3; expOut(8'h70, 4'd3, 1'b1); expAlarm(4'b0000); expErr(1'b0); applyStimulus("sel3");
    sel_ch = 4'd0; expOut(8'h0E, 4'd0, 1'b1); applyStimulus("sel0");
    doWrite(4'd0, 8'h0F); expOut(8'h0E, 4'd0, 1'b1); applyStimulus("wr_shown_prewrite");
    expOut(8'h0F, 4'd0, 1'b1); applyStimulus("wr_shown_new");
    doWrite(4'd4, 8'h99); expOut(8'h0F, 4'd0, 1'b1); applyStimulus("wr_bad_ch");
    expOut(8'h0F, 4'd0, 1'b1); applyStimulus("wr_bad_ch_ignored");

    // Thresholds, set/clear priority, and old-threshold use on a simultaneous reload.
    sel_ch = 4'd1; doThr(4'd1, 8'h10, 8'h20); expOut(8'h1C, 4'd1, 1'b1); applyStimulus("thr1");
    doThr(4'd4, 8'hF0, 8'hF0); expOut(8'h1C, 4'd1, 1'b1); applyStimulus("thr_bad_ch");
    doWrite(4'd1, 8'h21); expOut(8'h1C, 4'd1, 1'b1); expAlarm(4'b0010); applyStimulus("wr1_high");
    doWrite(4'd0, 8'h0E); expOut(8'h21, 4'd1, 1'b1); expAlarm(4'b0010); applyStimulus("ch0_thr_untouched");
    alarm_clr = 4'b0010; expAlarm(4'b0000); applyStimulus("clr1");
    doWrite(4'd1, 8'h20); expOut(8'h21, 4'd1, 1'b1); expAlarm(4'b0000); applyStimulus("eq_hi");
    doWrite(4'd1, 8'h10); expOut(8'h20, 4'd1, 1'b1); expAlarm(4'b0000); applyStimulus("eq_lo");
    doWrite(4'd1, 8'h05); alarm_clr = 4'b0010; expOut(8'h10, 4'd1, 1'b1); expAlarm(4'b0010);
    applyStimulus("set_wins");
    doWrite(4'd1, 8'h30); doThr(4'd1, 8'h00, 8'hFF); alarm_clr = 4'b0010; expOut(8'h05, 4'd1, 1'b1);
    expAlarm(4'b0010); applyStimulus("old_thr_used");
    doWrite(4'd1, 8'h30); alarm_clr = 4'b0010; expOut(8'h30, 4'd1, 1'b1); expAlarm(4'b0000);
    applyStimulus("new_thr_used");
    doThr(4'd3, 8'h80, 8'hFF); expAlarm(4'b0000); applyStimulus("no_reeval");
    doWrite(4'd3, 8'h70); expAlarm(4'b1000); applyStimulus("wr3_low");

    // Auto scan: four dwell cycles per channel, one-cycle wrap pulse.
    mode = 1'b1; sel_ch = 4'd2;
    for (int k = 0; k < 20; k++) begin
      expOut(scan_vals[(k / 4) % 4], 4'((k / 4) % 4), 1'b1);
      expWrap(k == 16);
      applyStimulus($sformatf("scan%0d", k));
    end
    mode = 1'b0; expOut(8'h0E, 4'd0, 1'b1); expWrap(1'b0); expErr(1'b0); applyStimulus("scan_exit");
    expOut(8'h38, 4'd2, 1'b1); applyStimulus("manual_after_scan");

    // Error entry, operation during error, and clearing.
    sel_ch = 4'd5; expOut(8'hFF, 4'hF, 1'b0); expErr(1'b1); applyStimulus("err_enter");
    doWrite(4'd2, 8'h44); alarm_clr = 4'b1000; expOut(8'hFF, 4'hF, 1'b0); expAlarm(4'b0000);
    expErr(1'b1); applyStimulus("err_write");
    err_clr = 1'b1; doWrite(4'd3, 8'h10); expOut(8'hFF, 4'hF, 1'b0); expAlarm(4'b1000);
    expErr(1'b1); applyStimulus("err_clr_bad_sel");
    sel_ch = 4'd2; expErr(1'b1); applyStimulus("err_hold");
    err_clr = 1'b1; expErr(1'b0); expOut(8'hFF, 4'hF, 1'b0); applyStimulus("err_clr");
    expOut(8'h44, 4'd2, 1'b1); expErr(1'b0); applyStimulus("after_err");

    // Reset in the middle of a scan with an alarm pending.
    mode = 1'b1;
    for (int k = 0; k < 9; k++) begin
      v = (k < 4) ? 8'h0E : (k < 8) ? 8'h30 : 8'h44;
      expOut(v, 4'(k / 4), 1'b1); expAlarm(4'b1000);
      applyStimulus($sformatf("prescan%0d", k));
    end
    reset = 1'b1;
    expOut(8'h00, 4'd0, 1'b0); expWrap(1'b0); expAlarm(4'b0000); expErr(1'b0);
    applyStimulus("mid_scan_reset");
    reset = 1'b0; mode = 1'b0; sel_ch = 4'd1;
    doWrite(4'd1, 8'h21); expOut(8'h00, 4'd1, 1'b1); expAlarm(4'b0000); applyStimulus("thr_restored1");
    doWrite(4'd3, 8'h00); expOut(8'h21, 4'd1, 1'b1); expAlarm(4'b0000); applyStimulus("thr_restored_lo");
    doWrite(4'd1, 8'hFF); expOut(8'h21, 4'd1, 1'b1); expAlarm(4'b0000); applyStimulus("thr_restored_hi");
    expOut(8'hFF, 4'd1, 1'b1); expAlarm(4'b0000); applyStimulus("final");

    repeat (3) @(posedge CLK);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
